// File: rtl/rv_arb_pkg.sv
// Shared constants, types and helpers for the round-robin ready/valid arbiter.
// Lock states are consumed only when RV_ARB_LOCK_EN is defined.
package rv_arb_pkg;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;

    // Packet-lock FSM: IDLE arbitrates every beat, LOCKED pins the grant.
    typedef enum logic [0:0] {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Width of a source index for n requesters (never below one bit).
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Combinational rotate-priority picker: the first set bit of req at or after
// ptr wins, wrapping modulo N back to index 0.
module rv_rr_pick
    import rv_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = src_w(N_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          any
);

    logic [N-1:0] hi_req;
    logic [SW-1:0] hi_grant;
    logic [SW-1:0] lo_grant;

    // Requests at or above the pointer take precedence over wrapped ones.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign hi_req[gi] = req[gi] && (gi >= int'(ptr));
        end
    endgenerate

    always_comb begin
        hi_grant = '0;
        lo_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                hi_grant = SW'(i);
            end
            if (req[i]) begin
                lo_grant = SW'(i);
            end
        end
    end

    assign any   = |req;
    assign grant = (|hi_req) ? hi_grant : lo_grant;

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter merging N ready/valid requesters into one registered
// egress beat tagged with its source. Define RV_ARB_LOCK_EN for packet locking.
module rv_rr_arbiter
    import rv_arb_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_valid,
    input  logic [N*DATA_W-1:0]   req_data,
    input  logic [N-1:0]          req_last,
    output logic [N-1:0]          req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [$clog2(N)-1:0]  out_src,
    output logic                  out_last
);

    localparam int SW = $clog2(N);

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [SW-1:0]     out_src_reg;
    logic              out_last_reg;
    logic [SW-1:0]     ptr_reg;

    logic [SW-1:0]     pick_grant;
    logic              pick_any;
    logic [SW-1:0]     grant;
    logic              accept;
    logic              xfer;
    logic [SW-1:0]     ptr_next;
    logic [DATA_W-1:0] data_arr [N];

    rv_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .any   (pick_any)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef RV_ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'(LOCK_IDLE);
    localparam logic [0:0] ST_LOCKED = 1'(LOCK_LOCKED);

    logic [0:0]    state_reg;
    logic [SW-1:0] lock_src_reg;

    // While locked, only the packet owner may be granted, valid or not.
    assign grant = (state_reg == ST_LOCKED) ? lock_src_reg : pick_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lock_src_reg <= '0;
        end else if (xfer) begin
            if (state_reg == ST_IDLE && !req_last[grant]) begin
                state_reg    <= ST_LOCKED;
                lock_src_reg <= grant;
            end else if (state_reg == ST_LOCKED && req_last[grant]) begin
                state_reg <= ST_IDLE;
            end
        end
    end
`else
    assign grant = pick_grant;
`endif

    assign accept = !out_valid_reg || out_ready;
    assign xfer   = accept && pick_any && req_valid[grant];

    // Ready is held low throughout reset even though the register reads empty.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && accept && pick_any && (grant == SW'(gi));
        end
    endgenerate

    assign ptr_next = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_last_reg  <= 1'b0;
            ptr_reg       <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[grant];
            out_src_reg   <= grant;
            out_last_reg  <= req_last[grant];
            ptr_reg       <= ptr_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Self-checking bench for rv_rr_arbiter: vector table, corner sequences and
// randomized traffic against a scan-based reference model.
module tb_rv_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_last;

    int n_tests = 0;
    int n_fail  = 0;

    rv_rr_arbiter #(.N(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Reference model state
    int           m_ptr, m_src, m_lock_src, m_g;
    bit           m_valid, m_last, m_locked, m_xfer;
    logic [DW-1:0] m_data;
    logic [N-1:0] m_ready;
    logic [N-1:0] ready_seen;

    typedef struct {
        logic [N-1:0]  rv;
        logic          ordy;
        logic [N-1:0]  exp_ready;
        logic          exp_valid;
        logic [SW-1:0] exp_src;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_src = 0; m_lock_src = 0;
        m_valid = 0; m_last = 0; m_locked = 0; m_data = '0;
    endfunction

    // Grant = first valid index walking ptr, ptr+1, ... modulo N.
    function automatic void model_comb();
        bit acc;
        acc = !m_valid || out_ready;
        m_g = 0;
        if (m_locked) begin
            m_g = m_lock_src;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
        end
        m_ready = (acc && (req_valid != 0)) ? N'(1 << m_g) : '0;
        m_xfer  = m_ready[m_g] && req_valid[m_g];
    endfunction

    function automatic void model_update();
        if (m_xfer) begin
            m_valid = 1;
            m_data  = req_data[m_g*DW +: DW];
            m_src   = m_g;
            m_last  = req_last[m_g];
            m_ptr   = (m_g + 1) % N;
`ifdef RV_ARB_LOCK_EN
            if (!m_locked && !req_last[m_g]) begin
                m_locked   = 1;
                m_lock_src = m_g;
            end else if (m_locked && req_last[m_g]) begin
                m_locked = 0;
            end
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endfunction

    // Inputs are already applied; check ready, clock once, check outputs.
    task automatic step(input bit chk);
        model_comb();
        #1;
        ready_seen = req_ready;
        if (chk) check("req_ready", 32'(req_ready), 32'(m_ready));
        @(posedge clk);
        model_update();
        #1;
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(m_data));
                check("out_src", 32'(out_src), 32'(m_src));
                check("out_last", 32'(out_last), 32'(m_last));
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [SW-1:0] exp_pkt [4];
        int sent;

        vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
        vecs[1]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[2]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        vecs[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h5A};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h5A};
        vecs[7]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h33};
        vecs[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h33};
        vecs[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        vecs[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};

        // Reset state, with requests pending to show ready stays low.
        rst_n = 1'b0;
        req_valid = 4'b1111; req_last = '1; req_data = 32'h335A2211; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_src", 32'(out_src), 32'h0);
        check("rst_last", 32'(out_last), 32'h0);
        req_valid = '0;
        rst_n = 1'b1;

        // Table-driven vectors, payload per requester fixed at 33/5A/22/11.
        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].rv;
            out_ready = vecs[i].ordy;
            step(1'b0);
            check($sformatf("vec%0d_ready", i), 32'(ready_seen), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].exp_src));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            $display("[TB] vec %0d rv=%b ordy=%b ready=%b valid=%b src=%0d data=%h",
                     i, vecs[i].rv, vecs[i].ordy, ready_seen, out_valid, out_src, out_data);
        end

        // Fairness: all requesters valid, egress always ready.
        do_reset();
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("fair_src", 32'(out_src), 32'(i % N));
            $display("[TB] fair beat %0d src=%0d", i, out_src);
        end

        // Packet of three beats from requester 0 competing with requester 1.
`ifdef RV_ARB_LOCK_EN
        exp_pkt = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
        exp_pkt = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        do_reset();
        sent = 0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req_valid = {2'b00, 1'b1, (sent < 3)};
            req_last  = {3'b111, (sent == 2)};
            step(1'b1);
            if (ready_seen[0]) sent++;
            check("pkt_src", 32'(out_src), 32'(exp_pkt[c]));
            $display("[TB] pkt beat %0d src=%0d last=%b", c, out_src, out_last);
        end

        // Asynchronous reset during a stall, then lowest valid index first.
        do_reset();
        req_last = '1; req_valid = 4'b1000; out_ready = 1'b0;
        step(1'b1);
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_src", 32'(out_src), 32'h0);
        check("async_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b0110; out_ready = 1'b1;
        step(1'b1);
        check("post_rst_grant", 32'(ready_seen), 32'h2);
        $display("[TB] async reset: post-reset grant=%b src=%0d", ready_seen, out_src);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            req_last  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'b1);
        end
        $display("[TB] random phase: 400 cycles");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_rr_arbiter.md
# rv_rr_arbiter

Round-robin arbiter that shares one registered ready/valid egress stage between N ready/valid requesters. Each cycle at most one requester's beat is accepted into a single output register (full throughput, no bubbles under continuous back-to-back traffic), tagged with its source index. It sits in front of the skid/valid register stages, merging several producer channels into one downstream consumer.

## Interface
- N, 4, number of requesters (2..16)
- DATA_W, 8, beat width in bits
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  requester i has a beat
- req_data  in  N x DATA_W  requester i beat payload
- req_last  in  N  final beat of a packet (used only with RV_ARB_LOCK_EN)
- req_ready  out  N  one-hot or zero; beat of requester i accepted this cycle
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered payload
- out_src  out  $clog2(N)  index of requester that produced out_data
- out_last  out  1  registered copy of accepted req_last

## Operation
- accept = !out_valid || out_ready (register empty or draining this cycle).
- Grant g = first i with req_valid[i] scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap modulo N).
- req_ready[g] = accept && any req_valid; all other req_ready = 0. req_ready never depends on req_valid of the same index beyond grant selection.
- On transfer (req_valid[g] && req_ready[g]): out_data<=req_data[g], out_src<=g, out_last<=req_last[g], out_valid<=1, ptr<=(g+1) mod N.
- If out_valid && out_ready && no transfer: out_valid<=0; data/src/last hold.
- No requester valid: ptr unchanged.
- Requester dropping valid without transfer is legal; it simply loses grant. Downstream must see out_data/out_src stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low, async): out_valid=0, out_data=0, out_src=0, out_last=0, ptr=0, lock state IDLE; req_ready=0 while in reset.
- Latency: beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: one beat/cycle when out_ready held high.
- Fairness: with all N valid continuously, grants cycle 0,1,..,N-1,0; no requester waits more than N-1 transfers.
- Reset deasserted mid-stall: in-flight beat discarded; first grant after reset goes to lowest valid index.

## Configuration
- RV_ARB_LOCK_EN defined: two-state FSM IDLE/LOCKED. In IDLE, transfer with req_last=0 -> LOCKED, lock_src<=g. In LOCKED, grant forced to lock_src (other requesters ready=0 even if lock_src not valid); transfer with req_last=1 -> IDLE, ptr<=(lock_src+1) mod N. Packets never interleave on the output.
- Undefined: no FSM, arbitration every beat; req_last only passed through to out_last.

## Structure
- Package rv_arb_pkg: DATA_W default constant, src index typedef helper, lock state enum (IDLE, LOCKED).
- Sub-module rv_rr_pick: combinational rotate-priority picker (inputs req vector, ptr; outputs grant index, any). Instantiated once in rv_rr_arbiter.

## Test plan
- Reset: assert rst_n=0 mid-transfer -> out_valid=0, out_src=0, req_ready=0 immediately, asynchronously.
- Single requester: req_valid=4'b0100, data 0x5A, out_ready=1 -> req_ready=4'b0100, next cycle out_valid=1, out_data=0x5A, out_src=2.
- Fairness: all four valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3.
- Backpressure: out_ready=0 with out_valid=1 -> req_ready=0, out_data/out_src held; release -> transfer resumes same cycle, no lost or duplicated beat.
- Skip/wrap: ptr=3, req_valid=4'b0011 -> grant 0, then ptr=1 -> grant 1.
- RV_ARB_LOCK_EN: req0 sends 3 beats (last on 3rd) while req1 valid -> out_src 0,0,0 then 1; without macro -> out_src 0,1,0,1 interleaved.
